// File: rtl/pwm_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_seq_pkg
// Description : Shared types and constants for the PWM sequencer.
//               - pwm_seq_state_t : sequencer FSM state encoding
//               - SRC_NORMAL / SRC_STM : requester source indices
//               - PWM_WIDTH / PWM_TRANS_NUM : defaults shared with the
//                 PWM datapath
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    DRAIN     = 3'd2,
    WAIT_DOUT = 3'd3,
    DONE      = 3'd4
  } pwm_seq_state_t;

  localparam logic SRC_NORMAL = 1'b0;
  localparam logic SRC_STM    = 1'b1;

  localparam int PWM_WIDTH     = 13;
  localparam int PWM_TRANS_NUM = 249;

endpackage
`default_nettype wire

// File: rtl/pwm_seq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pwm_seq_arbiter
// Description : Two-way round-robin arbiter. The grant is combinational; the
//               priority pointer updates only when the grant is taken.
// Ports       : clk, rst_n      - clock, async active-low reset
//               req[1:0]        - request levels
//               take            - grant accepted this cycle
//               gnt_valid       - at least one request pending
//               gnt_src         - winning source index
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_seq_arbiter
  import pwm_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_valid,
  output logic       gnt_src
);

  // prio_q holds the source that wins the next tie, i.e. the complement of
  // the last granted source. Resetting it to 0 lets source 0 win first.
  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt_valid = |req;
    gnt_src   = prio_q;
    case (req)
      2'b01:   gnt_src = SRC_NORMAL;
      2'b10:   gnt_src = SRC_STM;
      default: gnt_src = prio_q;
    endcase
    prio_d = prio_q;
    if (take && gnt_valid) begin
      prio_d = ~gnt_src;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pwm_sequencer
// Description : Arbitrating loader for the per-transducer PWM datapath.
//               Grants one of two requesters (0 = normal gain, 1 = STM),
//               streams that source's TRANS_NUM duty/phase entries with
//               DIN_VALID, waits for DOUT_VALID and pulses ACK[SRC].
// Ports       : CLK, RST_N           - clock, async active-low reset
//               REQ[1:0] / ACK[1:0]  - request levels / completion pulses
//               ERR                  - watchdog timeout pulse
//               BUSY, SRC            - frame in progress, granted source
//               RD_EN, RD_ADDR       - memory read strobe / entry index
//               RD_DUTY, RD_PHASE    - per-source read data, source s at
//                                      [s*WIDTH +: WIDTH]
//               DIN_VALID, DUTY, PHASE - datapath input stream
//               DOUT_VALID           - datapath finished
// Options     : PWM_SEQ_TIMEOUT_EN - enables the DOUT_VALID watchdog
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int WIDTH     = PWM_WIDTH,
  parameter int TRANS_NUM = PWM_TRANS_NUM,
  parameter int ADDR_W    = $clog2(TRANS_NUM),
  parameter int RD_LAT    = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [1:0]           REQ,
  output logic [1:0]           ACK,
  output logic                 ERR,
  output logic                 BUSY,
  output logic                 SRC,
  output logic                 RD_EN,
  output logic [ADDR_W-1:0]    RD_ADDR,
  input  logic [2*WIDTH-1:0]   RD_DUTY,
  input  logic [2*WIDTH-1:0]   RD_PHASE,
  output logic                 DIN_VALID,
  output logic [WIDTH-1:0]     DUTY,
  output logic [WIDTH-1:0]     PHASE,
  input  logic                 DOUT_VALID
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TRANS_NUM - 1);

  pwm_seq_state_t      state_q, state_d;
  logic                src_q, src_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  // vld_q[i] is RD_EN delayed by i+1 cycles; stage RD_LAT-1 marks read data
  // valid on the memory bus, stage RD_LAT is the registered output strobe.
  logic [RD_LAT:0]     vld_q, vld_d;
  logic [WIDTH-1:0]    duty_q, duty_d;
  logic [WIDTH-1:0]    phase_q, phase_d;

  logic                gnt_valid;
  logic                gnt_src;
  logic                take;
  logic                timeout_hit;
  logic                rd_en;

  pwm_seq_arbiter u_arbiter (
    .clk       (CLK),
    .rst_n     (RST_N),
    .req       (REQ),
    .take      (take),
    .gnt_valid (gnt_valid),
    .gnt_src   (gnt_src)
  );

  assign rd_en = (state_q == READ);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    addr_d  = addr_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          take    = 1'b1;
          src_d   = gnt_src;
          addr_d  = '0;
          state_d = READ;
        end
      end
      READ: begin
        // Address saturates at the last entry; it is cleared only on grant.
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        // Once no read is left in flight the last datum is on the outputs.
        if (vld_q[RD_LAT-1:0] == '0) begin
          state_d = WAIT_DOUT;
        end
      end
      WAIT_DOUT: begin
        if (DOUT_VALID || timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read-data pipeline: capture the granted source's data when valid.
  always_comb begin
    vld_d   = {vld_q[RD_LAT-1:0], rd_en};
    duty_d  = duty_q;
    phase_d = phase_q;
    if (vld_q[RD_LAT-1]) begin
      duty_d  = src_q ? RD_DUTY[2*WIDTH-1:WIDTH]  : RD_DUTY[WIDTH-1:0];
      phase_d = src_q ? RD_PHASE[2*WIDTH-1:WIDTH] : RD_PHASE[WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      src_q   <= 1'b0;
      addr_q  <= '0;
      vld_q   <= '0;
      duty_q  <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      duty_q  <= duty_d;
      phase_q <= phase_d;
    end
  end

`ifdef PWM_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;

  // Counter is held at zero outside WAIT_DOUT, so it is clear on entry.
  always_comb begin
    to_cnt_d    = '0;
    timeout_hit = 1'b0;
    if (state_q == WAIT_DOUT) begin
      to_cnt_d    = to_cnt_q + TO_W'(1);
      timeout_hit = (to_cnt_q == TO_W'(TIMEOUT - 1));
    end
    // ERR only when the watchdog, not DOUT_VALID, ends the wait.
    err_d = timeout_hit && !DOUT_VALID;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign timeout_hit = 1'b0;
  assign ERR         = 1'b0;
`endif

  assign BUSY      = (state_q != IDLE);
  assign SRC       = src_q;
  assign RD_EN     = rd_en;
  assign RD_ADDR   = addr_q;
  assign DIN_VALID = vld_q[RD_LAT];
  assign DUTY      = duty_q;
  assign PHASE     = phase_q;
  assign ACK       = (state_q == DONE) ? (src_q ? 2'b10 : 2'b01) : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_pwm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_sequencer
// Description : Directed self-checking bench for pwm_sequencer. Source 0
//               memory returns duty=k, phase=2k; source 1 returns
//               duty=1000+k, phase=3000+k, both with two-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_sequencer;

  localparam int WIDTH  = 13;
  localparam int TN     = 249;
  localparam int AW     = 8;
  localparam int RD_LAT = 2;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [1:0]      REQ = 2'b00;
  logic [1:0]      ACK;
  logic            ERR;
  logic            BUSY;
  logic            SRC;
  logic            RD_EN;
  logic [AW-1:0]   RD_ADDR;
  logic [2*WIDTH-1:0] RD_DUTY;
  logic [2*WIDTH-1:0] RD_PHASE;
  logic            DIN_VALID;
  logic [WIDTH-1:0] DUTY;
  logic [WIDTH-1:0] PHASE;
  logic            DOUT_VALID = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  pwm_sequencer #(
    .WIDTH     (WIDTH),
    .TRANS_NUM (TN),
    .ADDR_W    (AW),
    .RD_LAT    (RD_LAT),
    .TIMEOUT   (64)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .REQ        (REQ),
    .ACK        (ACK),
    .ERR        (ERR),
    .BUSY       (BUSY),
    .SRC        (SRC),
    .RD_EN      (RD_EN),
    .RD_ADDR    (RD_ADDR),
    .RD_DUTY    (RD_DUTY),
    .RD_PHASE   (RD_PHASE),
    .DIN_VALID  (DIN_VALID),
    .DUTY       (DUTY),
    .PHASE      (PHASE),
    .DOUT_VALID (DOUT_VALID)
  );

  always #5 CLK = ~CLK;

  // Memory model: address registered twice, data valid two cycles after RD_EN.
  logic [AW-1:0] a0 = '0;
  logic [AW-1:0] a1 = '0;
  always @(posedge CLK) begin
    a0 <= RD_ADDR;
    a1 <= a0;
  end
  assign RD_DUTY  = {WIDTH'(1000 + int'(a1)), WIDTH'(a1)};
  assign RD_PHASE = {WIDTH'(3000 + int'(a1)), WIDTH'(2 * int'(a1))};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_zero_outs();
    chk("z_ack",   32'(ACK), 0);
    chk("z_err",   32'(ERR), 0);
    chk("z_busy",  32'(BUSY), 0);
    chk("z_src",   32'(SRC), 0);
    chk("z_rden",  32'(RD_EN), 0);
    chk("z_addr",  32'(RD_ADDR), 0);
    chk("z_dinv",  32'(DIN_VALID), 0);
    chk("z_duty",  32'(DUTY), 0);
    chk("z_phase", 32'(PHASE), 0);
  endtask

  // Called in the first granted cycle (g+1). With use_dout, returns in the
  // ACK cycle; otherwise returns in the first WAIT_DOUT cycle.
  task automatic frame(input int exp_src, input int drop_at, input bit use_dout);
    int exp_addr;
    chk("g_busy", 32'(BUSY), 1);
    chk("g_src",  32'(SRC), 32'(exp_src));
    chk("g_rden", 32'(RD_EN), 1);
    chk("g_addr", 32'(RD_ADDR), 0);
    chk("g_dinv", 32'(DIN_VALID), 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("pre_addr", 32'(RD_ADDR), 32'(i));
      if (i < 3) chk("pre_dinv", 32'(DIN_VALID), 0);
    end
    for (int k = 0; k < TN; k++) begin
      exp_addr = (3 + k > TN - 1) ? TN - 1 : 3 + k;
      chk("s_addr",  32'(RD_ADDR), 32'(exp_addr));
      chk("s_rden",  32'(RD_EN), 32'(k <= TN - 4));
      chk("s_dinv",  32'(DIN_VALID), 1);
      chk("s_duty",  32'(DUTY),  32'(exp_src == 1 ? 1000 + k : k));
      chk("s_phase", 32'(PHASE), 32'(exp_src == 1 ? 3000 + k : 2 * k));
      chk("s_ack",   32'(ACK), 0);
      DOUT_VALID = (k == 50);
      if (exp_addr == drop_at) REQ[exp_src] = 1'b0;
      step();
    end
    chk("post_dinv", 32'(DIN_VALID), 0);
    chk("post_busy", 32'(BUSY), 1);
    if (use_dout) begin
      for (int i = 0; i < 10; i++) begin
        step();
        chk("w_ack",  32'(ACK), 0);
        chk("w_busy", 32'(BUSY), 1);
      end
      DOUT_VALID = 1'b1;
      step();
      DOUT_VALID = 1'b0;
      chk("ack",      32'(ACK), 32'(exp_src == 1 ? 2 : 1));
      chk("ack_err",  32'(ERR), 0);
      chk("ack_busy", 32'(BUSY), 1);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk_zero_outs();
    RST_N = 1'b1;

    // Single request from source 0
    REQ = 2'b01;
    step();
    frame(0, -1, 1'b1);
    REQ = 2'b00;
    step();
    chk("t1_idle_busy", 32'(BUSY), 0);
    chk("t1_idle_ack",  32'(ACK), 0);
    step();
    chk("t1_stay_idle", 32'(BUSY), 0);

    // Both requesting from reset: grants alternate 0,1,0,1
    RST_N = 1'b0;
    REQ   = 2'b11;
    step();
    step();
    RST_N = 1'b1;
    step();
    for (int f = 0; f < 4; f++) begin
      frame(f % 2, -1, 1'b1);
      if (f == 3) REQ = 2'b00;
      step();
      chk("rr_gap_busy", 32'(BUSY), 0);
      step();
      chk("rr_next_busy", 32'(BUSY), 32'(f < 3));
    end

    // Source 1 drops its request mid-frame
    REQ = 2'b10;
    step();
    frame(1, 100, 1'b1);
    chk("drop_req", 32'(REQ), 0);
    step();
    chk("drop_idle", 32'(BUSY), 0);
    step();
    chk("drop_stay_idle", 32'(BUSY), 0);

    // Reset in the middle of a frame
    REQ = 2'b01;
    step();
    repeat (50) step();
    chk("mid_addr", 32'(RD_ADDR), 50);
    chk("mid_dinv", 32'(DIN_VALID), 1);
    RST_N = 1'b0;
    #1;
    chk_zero_outs();
    step();
    step();
    RST_N = 1'b1;
    step();
    frame(0, -1, 1'b1);
    REQ = 2'b00;
    step();
    chk("rst_idle", 32'(BUSY), 0);

    // No DOUT_VALID at all
    REQ = 2'b01;
    step();
    frame(0, -1, 1'b0);
`ifdef PWM_SEQ_TIMEOUT_EN
    repeat (63) step();
    chk("to_err_early", 32'(ERR), 0);
    chk("to_ack_early", 32'(ACK), 0);
    step();
    chk("to_err", 32'(ERR), 1);
    chk("to_ack", 32'(ACK), 1);
    REQ = 2'b00;
    step();
    chk("to_busy", 32'(BUSY), 0);
    chk("to_err_done", 32'(ERR), 0);
`else
    repeat (100) step();
    chk("nto_busy", 32'(BUSY), 1);
    chk("nto_ack",  32'(ACK), 0);
    chk("nto_err",  32'(ERR), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
